// File: rtl/rom_rd_arb.sv
// Two-requester round-robin read arbiter in front of a synchronous ROM.
// Each accepted read carries a tag down an RD_LAT-deep pipeline to route rom_q back.
module rom_rd_arb #(
  parameter int unsigned AW     = 5,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q
);

  logic              last_gnt;
  logic [AW-1:0]     addr_q;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_id;
  logic              accept;

  // Grants are gated by rst_n so nothing is offered while reset is held.
  assign gnt0   = rst_n & req0 & (~req1 | last_gnt);
  assign gnt1   = rst_n & req1 & (~req0 | ~last_gnt);
  assign accept = gnt0 | gnt1;

  always_comb begin
    rom_addr = addr_q;
    if (gnt0)
      rom_addr = addr0;
    else if (gnt1)
      rom_addr = addr1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      addr_q   <= '0;
      tag_v    <= '0;
      tag_id   <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      if (accept) begin
        last_gnt <= gnt1;
        addr_q   <= rom_addr;
      end
      tag_v[0]  <= accept;
      tag_id[0] <= gnt1;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      // Tag leaving the last stage lines up with the ROM data for that read.
      rvalid0 <= tag_v[RD_LAT-1] & ~tag_id[RD_LAT-1];
      rvalid1 <= tag_v[RD_LAT-1] &  tag_id[RD_LAT-1];
      if (tag_v[RD_LAT-1] && !tag_id[RD_LAT-1])
        rdata0 <= rom_q;
      if (tag_v[RD_LAT-1] && tag_id[RD_LAT-1])
        rdata1 <= rom_q;
    end
  end

endmodule

// File: tb/tb_rom_rd_arb.sv
// Testbench for rom_rd_arb: directed scenarios plus randomized traffic against a
// transaction-level model (grant rule, pending-return queue, ROM q = addr + 0x10).
module tb_rom_rd_arb;
  localparam int unsigned AW = 5, DW = 8, RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1, rom_q;
  logic [AW-1:0] rom_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rom_rd_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_addr(rom_addr), .rom_q(rom_q)
  );

  // Synchronous ROM: data for an address appears RD_LAT cycles after it is presented.
  logic [AW-1:0] rp [RD_LAT];
  always @(posedge clk) begin
    rp[0] <= rom_addr;
    for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
  end
  assign rom_q = 8'(rp[RD_LAT-1]) + 8'h10;

  // Reference model state
  bit            m_last;
  bit            m_acc0, m_acc1;
  logic [AW-1:0] m_haddr;
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  int unsigned   p_cnt[$];
  bit            p_id[$];
  logic [DW-1:0] p_dat[$];

  function automatic void pick(input bit r0, input bit r1, input bit last,
                               output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (r0 && r1) begin
      if (last) g0 = 1'b1;
      else g1 = 1'b1;
    end else if (r0) g0 = 1'b1;
    else if (r1) g1 = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit g0, g1;
    if (!rst_n) begin
      m_last = 1'b1; m_haddr = '0; m_acc0 = 1'b0; m_acc1 = 1'b0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
      p_cnt.delete(); p_id.delete(); p_dat.delete();
    end else begin
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      foreach (p_cnt[i]) p_cnt[i] = p_cnt[i] - 1;
      if (p_cnt.size() > 0 && p_cnt[0] == 0) begin
        if (p_id[0]) begin m_rv1 = 1'b1; m_rd1 = p_dat[0]; end
        else begin m_rv0 = 1'b1; m_rd0 = p_dat[0]; end
        void'(p_cnt.pop_front()); void'(p_id.pop_front()); void'(p_dat.pop_front());
      end
      pick(req0, req1, m_last, g0, g1);
      m_acc0 = g0;
      m_acc1 = g1;
      if (g0 || g1) begin
        m_last  = g1;
        m_haddr = g1 ? addr1 : addr0;
        p_cnt.push_back(RD_LAT);
        p_id.push_back(g1);
        p_dat.push_back(8'(m_haddr) + 8'h10);
      end
    end
  end

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 5'd9; addr1 = 5'd22;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%0b exp=0", gnt0); end
    total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%0b exp=0", gnt1); end
    total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL reset_rvalid0 got=%0b exp=0", rvalid0); end
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL reset_rvalid1 got=%0b exp=0", rvalid1); end
    total++; if (rdata0 !== 8'h00) begin bad++; $display("FAIL reset_rdata0 got=%0h exp=0", rdata0); end
    total++; if (rdata1 !== 8'h00) begin bad++; $display("FAIL reset_rdata1 got=%0h exp=0", rdata1); end
    total++; if (rom_addr !== 5'd0) begin bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req0 = 1'b1; addr0 = 5'd3;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL single_gnt0 got=%0b exp=1", gnt0); end
    total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL single_gnt1 got=%0b exp=0", gnt1); end
    total++; if (rom_addr !== 5'd3) begin bad++; $display("FAIL single_rom_addr got=%0d exp=3", rom_addr); end
    @(posedge clk); #1;
    req0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bit e;
      e = (k == 3);
      @(negedge clk);
      total++; if (rvalid0 !== e) begin bad++; $display("FAIL single_rvalid0 k=%0d got=%0b exp=%0b", k, rvalid0, e); end
      total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL single_rvalid1 k=%0d got=%0b exp=0", k, rvalid1); end
      if (k == 3) begin
        total++; if (rdata0 !== 8'h13) begin bad++; $display("FAIL single_rdata0 got=%0h exp=13", rdata0); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 5'd1; addr1 = 5'd2;
    for (int i = 0; i < 10; i++) begin
      bit e0;
      @(negedge clk);
      total++; if (gnt0 !== (i % 2 == 0)) begin bad++; $display("FAIL cont_gnt0 i=%0d got=%0b exp=%0b", i, gnt0, i % 2 == 0); end
      total++; if (gnt1 !== (i % 2 == 1)) begin bad++; $display("FAIL cont_gnt1 i=%0d got=%0b exp=%0b", i, gnt1, i % 2 == 1); end
      if (i >= 3) begin
        e0 = ((i - 3) % 2 == 0);
        total++; if (rvalid0 !== e0) begin bad++; $display("FAIL cont_rvalid0 i=%0d got=%0b exp=%0b", i, rvalid0, e0); end
        total++; if (rvalid1 !== !e0) begin bad++; $display("FAIL cont_rvalid1 i=%0d got=%0b exp=%0b", i, rvalid1, !e0); end
        if (e0) begin
          total++; if (rdata0 !== 8'h11) begin bad++; $display("FAIL cont_rdata0 i=%0d got=%0h exp=11", i, rdata0); end
        end else begin
          total++; if (rdata1 !== 8'h12) begin bad++; $display("FAIL cont_rdata1 i=%0d got=%0h exp=12", i, rdata1); end
        end
      end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_pointer_hold();
    req1 = 1'b1; addr1 = 5'd4;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin bad++; $display("FAIL ptr_first got=%0b%0b exp=10", gnt1, gnt0); end
    @(posedge clk); #1;
    req1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({gnt1, gnt0} !== 2'b00) begin bad++; $display("FAIL ptr_idle k=%0d got=%0b%0b exp=00", k, gnt1, gnt0); end
      @(posedge clk); #1;
    end
    req0 = 1'b1; req1 = 1'b1; addr0 = 5'd5;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL ptr_gnt0 got=%0b exp=1", gnt0); end
    total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL ptr_gnt1 got=%0b exp=0", gnt1); end
    @(posedge clk); #1;
    idle(4);
  endtask

  task automatic test_addr_hold();
    req1 = 1'b1; addr1 = 5'd31;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL hold_gnt1 got=%0b exp=1", gnt1); end
    total++; if (rom_addr !== 5'd31) begin bad++; $display("FAIL hold_grant_addr got=%0d exp=31", rom_addr); end
    @(posedge clk); #1;
    req1 = 1'b0; addr1 = 5'd6;
    for (int k = 1; k <= 6; k++) begin
      bit e;
      e = (k == 3);
      @(negedge clk);
      total++; if (rom_addr !== 5'd31) begin bad++; $display("FAIL hold_rom_addr k=%0d got=%0d exp=31", k, rom_addr); end
      total++; if (rvalid1 !== e) begin bad++; $display("FAIL hold_rvalid1 k=%0d got=%0b exp=%0b", k, rvalid1, e); end
      total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL hold_rvalid0 k=%0d got=%0b exp=0", k, rvalid0); end
      if (e) begin
        total++; if (rdata1 !== 8'h2F) begin bad++; $display("FAIL hold_rdata1 got=%0h exp=2f", rdata1); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    req0 = 1'b1; addr0 = 5'd7;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL mid_gnt0 got=%0b exp=1", gnt0); end
    @(posedge clk); #1;
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    total++; if (rom_addr !== 5'd0) begin bad++; $display("FAIL mid_rom_addr got=%0d exp=0", rom_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL mid_rvalid0 k=%0d got=%0b exp=0", k, rvalid0); end
      total++; if (rdata0 !== 8'h00) begin bad++; $display("FAIL mid_rdata0 k=%0d got=%0h exp=0", k, rdata0); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      bit e0, e1;
      logic [AW-1:0] ea;
      // A request not yet accepted must stay up with the same address.
      if (!(req0 && !m_acc0)) begin req0 = ($urandom_range(0, 99) < 60); addr0 = AW'($urandom); end
      if (!(req1 && !m_acc1)) begin req1 = ($urandom_range(0, 99) < 60); addr1 = AW'($urandom); end
      @(negedge clk);
      pick(req0, req1, m_last, e0, e1);
      ea = e0 ? addr0 : (e1 ? addr1 : m_haddr);
      total++; if (gnt0 !== e0) begin bad++; $display("FAIL rnd_gnt0 c=%0d got=%0b exp=%0b", c, gnt0, e0); end
      total++; if (gnt1 !== e1) begin bad++; $display("FAIL rnd_gnt1 c=%0d got=%0b exp=%0b", c, gnt1, e1); end
      total++; if (rom_addr !== ea) begin bad++; $display("FAIL rnd_rom_addr c=%0d got=%0d exp=%0d", c, rom_addr, ea); end
      total++; if (rvalid0 !== m_rv0) begin bad++; $display("FAIL rnd_rvalid0 c=%0d got=%0b exp=%0b", c, rvalid0, m_rv0); end
      total++; if (rvalid1 !== m_rv1) begin bad++; $display("FAIL rnd_rvalid1 c=%0d got=%0b exp=%0b", c, rvalid1, m_rv1); end
      total++; if (rdata0 !== m_rd0) begin bad++; $display("FAIL rnd_rdata0 c=%0d got=%0h exp=%0h", c, rdata0, m_rd0); end
      total++; if (rdata1 !== m_rd1) begin bad++; $display("FAIL rnd_rdata1 c=%0d got=%0h exp=%0h", c, rdata1, m_rd1); end
      @(posedge clk); #1;
    end
    idle(5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_pointer_hold();
    test_addr_hold();
    test_reset_midflight();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
